afe_spi_txn_ctrl: RTL and testbench
===================================

Name: afe_spi_txn_ctrl

Overview:
- Transaction sequencer in front of the byte-level `spi` engine that drives the AFE4403 serial interface.
- Turns one host command into a complete AFE4403 register frame:
  - Write: 8-bit address followed by 24-bit data, MSB first.
  - Read: 8-bit address written, then 24 bits read.
- Drives the engine's wr_en/rd_en/flag/stage_rst/tx_data and consumes spi_done/rx_data.
- Keeps chip-select low for the whole frame and enforces a chip-select-high gap between frames.

Parameters:
- CS_GAP, 2: div_clk cycles with all engine controls low (spiste high) after each frame; legal range 1..15.
- CTRL0_ADDR, 8'h00: AFE4403 CONTROL0 register address; used only by the optional feature.

Ports:
- div_clk  in  1  clock (same clock as the `spi` engine).
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge with cmd_valid and cmd_ready both high.
- cmd_rw  in  1  0 = register write, 1 = register read.
- cmd_addr  in  8  register address.
- cmd_wdata  in  24  write data; ignored for reads.
- txn_done  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  24  read data; valid from txn_done until the next accept.
- busy  out  1  high whenever the state is not IDLE.
- spi_done  in  1  byte-complete pulse from the engine.
- rx_data  in  8  received byte from the engine.
- wr_en  out  1  engine write-byte enable.
- rd_en  out  1  engine read-byte enable.
- flag  out  1  holds engine chip-select low between bytes.
- stage_rst  out  1  engine synchronous clear.
- tx_data  out  8  byte presented to the engine.

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready = 1.
  - State IDLE; byte index 0; captured command registers cleared.
- All outputs are registered.
- State machine: IDLE -> START -> WR_BYTE -> (RD_BYTE) -> GAP -> DONE -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch rw, addr, wdata; set byte index 0; go to START.
- START (1 cycle):
  - stage_rst = 1; tx_data = addr; go to WR_BYTE.
- WR_BYTE:
  - wr_en = 1, flag = 1.
  - The engine spends 16 cycles per byte, with spi_done visible in the 16th cycle.
  - On an edge with spi_done = 1:
    - Write command: load tx_data with wdata[23:16], then [15:8], then [7:0] so the engine samples the new bit 7 on its next cycle. After the 4th byte, go to GAP.
    - Read command: after byte 0, go to RD_BYTE.
  - A write frame holds wr_en high for exactly 64 consecutive cycles.
- RD_BYTE:
  - rd_en = 1, flag = 1.
  - On an edge with spi_done = 1: capture rx_data into rsp_rdata[23:16], then [15:8], then [7:0].
  - After the 3rd byte, go to GAP.
  - rd_en is high for 49 cycles; the extra final cycle is a benign engine count-0 cycle with sclk low.
- GAP:
  - wr_en = rd_en = flag = stage_rst = 0 for CS_GAP cycles (engine idles, spiste high).
  - Then go to DONE, or to the next sub-frame when the optional feature is enabled.
- DONE:
  - txn_done = 1 for one cycle; go to IDLE.
- wr_en and rd_en are never high in the same cycle.
- flag is high exactly while wr_en or rd_en is high.
- A spi_done seen in IDLE, START, GAP or DONE is ignored.
- cmd_valid while busy: held off by cmd_ready = 0; the command is not lost and is accepted on return to IDLE.
- rst mid-frame: immediate return to reset values. The engine shares rst, so the bus goes idle.

Optional Feature:
- Macro: AFE_SPI_RDEN_SEQ_EN.
- Defined — a read command expands to three frames, each followed by a GAP:
  1. Write CTRL0_ADDR with 24'h000001 (set SPI_READ).
  2. Read frame.
  3. Write CTRL0_ADDR with 24'h000000.
- Defined — txn_done pulses only after the third frame's GAP.
- Not defined: a read is a single read frame, and the host must set SPI_READ itself.
- Write commands are identical in both builds.

Decomposition:
- Package afe_spi_pkg holds:
  - State enum.
  - Constants: frame byte counts (4 write, 1+3 read), the engine cycle count of 16 per byte, CTRL0 SPI_READ value 24'h000001.
- No sub-module needed; the datapath is three byte muxes and a shift/capture register.
- The bench instantiates afe_spi_txn_ctrl together with `spi` and an AFE4403 slave model.

Test Plan:
- Write addr 8'h01, wdata 24'hABCDEF -> slave sees bytes 01 AB CD EF MSB first; wr_en high 64 cycles; spiste high CS_GAP cycles; txn_done pulses once.
- Read addr 8'h2A, slave returns 24'h123456 -> rsp_rdata = 24'h123456 at txn_done; 8 sclk rises with wr_en then 24 with rd_en; chip-select low across the write-to-read boundary.
- Back-to-back commands with cmd_valid held -> second accept only after DONE; spiste high ≥ CS_GAP cycles between frames.
- rst asserted at byte 2 of a write -> all outputs at reset values on the same cycle, spiste high; next command completes normally.
- With AFE_SPI_RDEN_SEQ_EN, read addr 8'h2A -> three frames: 00 000001, then 2A + read, then 00 000000; a single txn_done.
- Spurious spi_done pulse injected in IDLE -> no state change and no txn_done.

Source files
------------

// File: rtl/afe_spi_txn_ctrl_pkg.sv
// afe_spi_pkg: shared types and constants for the AFE4403 SPI transaction sequencer.
//   state_t       sequencer states
//   WR_BYTES      bytes in a register-write frame (address + 3 data)
//   RD_ADDR_BYTES bytes written at the start of a read frame (address)
//   RD_DATA_BYTES bytes read back in a read frame
//   BYTE_CYCLES   div_clk cycles the spi engine spends per byte
//   SPI_READ      CONTROL0 value that enables register read-back
package afe_spi_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WR_BYTE,
        S_RD_BYTE,
        S_GAP,
        S_DONE
    } state_t;
    localparam int          WR_BYTES      = 4;
    localparam int          RD_ADDR_BYTES = 1;
    localparam int          RD_DATA_BYTES = 3;
    localparam int          BYTE_CYCLES   = 16;
    localparam logic [23:0] SPI_READ      = 24'h000001;
endpackage

// File: rtl/afe_spi_txn_ctrl_if.sv
// afe_spi_txn_ctrl_if: host command/response bundle of the AFE4403 transaction sequencer.
//   cmd_valid/cmd_ready  command handshake (accept when both high on a div_clk edge)
//   cmd_rw               0 = register write, 1 = register read
//   cmd_addr/cmd_wdata   register address and write data
//   txn_done             one-cycle completion pulse
//   rsp_rdata            read data, valid from txn_done until the next accept
//   busy                 sequencer not idle
//   master: host side; slave: sequencer side
interface afe_spi_txn_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [7:0]  cmd_addr;
    logic [23:0] cmd_wdata;
    logic        txn_done;
    logic [23:0] rsp_rdata;
    logic        busy;
    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, txn_done, rsp_rdata, busy
    );
    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, txn_done, rsp_rdata, busy
    );
endinterface

// File: rtl/afe_spi_txn_ctrl.sv
// afe_spi_txn_ctrl: turns one host command into a complete AFE4403 register frame on the byte-level spi engine.
//   div_clk    clock shared with the spi engine
//   rst        asynchronous active-high reset (shared with the engine)
//   host       command/response bundle (afe_spi_txn_ctrl_if.slave)
//   spi_done   byte-complete pulse from the engine
//   rx_data    byte received by the engine
//   wr_en      engine write-byte enable
//   rd_en      engine read-byte enable
//   flag       holds engine chip-select low between bytes
//   stage_rst  engine synchronous clear
//   tx_data    byte presented to the engine
// Optional build macro AFE_SPI_RDEN_SEQ_EN: a read expands to CONTROL0 SPI_READ set,
// the read frame, then CONTROL0 clear, with a single txn_done at the end.
module afe_spi_txn_ctrl
    import afe_spi_pkg::*;
#(
    parameter int         CS_GAP     = 2,
    parameter logic [7:0] CTRL0_ADDR = 8'h00
) (
    input  logic              div_clk,
    input  logic              rst,
    afe_spi_txn_ctrl_if.slave host,
    input  logic              spi_done,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic              flag,
    output logic              stage_rst,
    output logic [7:0]        tx_data
);

`ifdef AFE_SPI_RDEN_SEQ_EN
    localparam logic SEQ_EN = 1'b1;
`else
    localparam logic SEQ_EN = 1'b0;
`endif

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [1:0]  left, left_n;
    logic [3:0]  gap, gap_n;
    logic        c_rw, c_rw_n;
    logic [7:0]  c_addr, c_addr_n;
    logic [23:0] c_wdata, c_wdata_n;
    logic [23:0] rdata_n;
    logic [7:0]  tx_n;
    logic        f_rw;
    logic [7:0]  f_addr;
    logic [23:0] f_wdata;
    logic        unused_cfg;

    assign unused_cfg = ^{CTRL0_ADDR, SPI_READ, BYTE_CYCLES};

    // Frame currently on the bus; left counts the sub-frames still to run after it.
`ifdef AFE_SPI_RDEN_SEQ_EN
    always_comb begin
        f_rw    = c_rw && left == 2'd1;
        f_addr  = (c_rw && left != 2'd1) ? CTRL0_ADDR : c_addr;
        f_wdata = !c_rw ? c_wdata : (left == 2'd2 ? SPI_READ : 24'h0);
    end
`else
    always_comb begin
        f_rw    = c_rw;
        f_addr  = c_addr;
        f_wdata = c_wdata;
    end
`endif

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        left_n    = left;
        gap_n     = gap;
        c_rw_n    = c_rw;
        c_addr_n  = c_addr;
        c_wdata_n = c_wdata;
        rdata_n   = host.rsp_rdata;
        tx_n      = tx_data;
        case (state)
            S_IDLE: begin
                if (host.cmd_valid && host.cmd_ready) begin
                    c_rw_n    = host.cmd_rw;
                    c_addr_n  = host.cmd_addr;
                    c_wdata_n = host.cmd_wdata;
                    left_n    = (SEQ_EN && host.cmd_rw) ? 2'd2 : 2'd0;
                    idx_n     = 2'd0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                tx_n    = f_addr;
                idx_n   = 2'd0;
                state_n = S_WR_BYTE;
            end
            S_WR_BYTE: begin
                if (spi_done) begin
                    if (idx == (f_rw ? 2'(RD_ADDR_BYTES - 1) : 2'(WR_BYTES - 1))) begin
                        idx_n   = 2'd0;
                        gap_n   = 4'd0;
                        state_n = f_rw ? S_RD_BYTE : S_GAP;
                    end else begin
                        // Loaded on the done edge so the engine shifts the new bit 7 next cycle.
                        idx_n = idx + 2'd1;
                        tx_n  = idx == 2'd0 ? f_wdata[23:16] : idx == 2'd1 ? f_wdata[15:8] : f_wdata[7:0];
                    end
                end
            end
            S_RD_BYTE: begin
                // One extra cycle after the last byte: the engine's harmless count-0 cycle.
                if (idx == 2'(RD_DATA_BYTES)) begin
                    gap_n   = 4'd0;
                    state_n = S_GAP;
                end else if (spi_done) begin
                    idx_n   = idx + 2'd1;
                    rdata_n = {host.rsp_rdata[15:0], rx_data};
                end
            end
            S_GAP: begin
                if (gap == 4'(CS_GAP - 1)) begin
                    if (left == 2'd0) begin
                        state_n = S_DONE;
                    end else begin
                        left_n  = left - 2'd1;
                        state_n = S_START;
                    end
                end else begin
                    gap_n = gap + 4'd1;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= 2'd0;
            left           <= 2'd0;
            gap            <= 4'd0;
            c_rw           <= 1'b0;
            c_addr         <= 8'h0;
            c_wdata        <= 24'h0;
            wr_en          <= 1'b0;
            rd_en          <= 1'b0;
            flag           <= 1'b0;
            stage_rst      <= 1'b0;
            tx_data        <= 8'h0;
            host.cmd_ready <= 1'b1;
            host.busy      <= 1'b0;
            host.txn_done  <= 1'b0;
            host.rsp_rdata <= 24'h0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            left           <= left_n;
            gap            <= gap_n;
            c_rw           <= c_rw_n;
            c_addr         <= c_addr_n;
            c_wdata        <= c_wdata_n;
            wr_en          <= state_n == S_WR_BYTE;
            rd_en          <= state_n == S_RD_BYTE;
            flag           <= state_n == S_WR_BYTE || state_n == S_RD_BYTE;
            stage_rst      <= state_n == S_START;
            tx_data        <= tx_n;
            host.cmd_ready <= state_n == S_IDLE;
            host.busy      <= state_n != S_IDLE;
            host.txn_done  <= state_n == S_DONE;
            host.rsp_rdata <= rdata_n;
        end
    end

endmodule

// File: tb/tb_afe_spi_txn_ctrl.sv
// tb_afe_spi_txn_ctrl: directed bench for afe_spi_txn_ctrl with a behavioural spi engine and AFE4403 slave.
module tb_afe_spi_txn_ctrl;
    localparam int CS_GAP = 2;

    logic        div_clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_done;
    logic [7:0]  rx_data;
    logic        wr_en, rd_en, flag, stage_rst;
    logic [7:0]  tx_data;

    afe_spi_txn_ctrl_if bus();

    afe_spi_txn_ctrl #(.CS_GAP(CS_GAP), .CTRL0_ADDR(8'h00)) dut (
        .div_clk(div_clk), .rst(rst), .host(bus), .spi_done(spi_done), .rx_data(rx_data),
        .wr_en(wr_en), .rd_en(rd_en), .flag(flag), .stage_rst(stage_rst), .tx_data(tx_data)
    );

    always #5 div_clk = ~div_clk;

    // Engine model: 16 cycles per byte, done in the 16th, bit shifted on odd counts.
    logic [3:0]  cnt;
    logic [4:0]  rb;
    logic [7:0]  rx_sh;
    logic [23:0] slave_val = 24'h0;
    logic        inj = 1'b0;
    logic        mosi, miso, spiste;

    assign mosi     = tx_data[3'd7 - cnt[3:1]];
    assign miso     = rb < 5'd24 ? slave_val[5'd23 - rb] : 1'b0;
    assign spi_done = ((wr_en | rd_en) && cnt == 4'd15) || inj;
    assign rx_data  = {rx_sh[6:0], miso};
    assign spiste   = ~flag;

    always @(posedge div_clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0; rb <= 5'd0; rx_sh <= 8'h0;
        end else if (stage_rst) begin
            cnt <= 4'd0; rb <= 5'd0; rx_sh <= 8'h0;
        end else if (wr_en | rd_en) begin
            cnt <= cnt + 4'd1;
            if (cnt[0]) rx_sh <= {rx_sh[6:0], miso};
            if (rd_en && cnt[0]) rb <= rb + 5'd1;
        end else begin
            cnt <= 4'd0;
        end
    end

    // Bus monitor
    logic        clr_mon = 1'b0;
    logic        flag_q = 1'b0;
    int          wr_cyc, rd_cyc, wr_rise, rd_rise, cs_rise, gap_run, min_gap, dcnt, acc;
    int          inv = 0;
    logic [63:0] mosi_sh;

    always @(posedge div_clk) begin
        if (clr_mon) begin
            wr_cyc <= 0; rd_cyc <= 0; wr_rise <= 0; rd_rise <= 0; cs_rise <= 0;
            gap_run <= 0; min_gap <= 99; dcnt <= 0; acc <= 0; mosi_sh <= 64'h0;
        end else begin
            if (wr_en) wr_cyc <= wr_cyc + 1;
            if (rd_en) rd_cyc <= rd_cyc + 1;
            if (wr_en && cnt[0]) begin
                wr_rise <= wr_rise + 1;
                mosi_sh <= {mosi_sh[62:0], mosi};
            end
            if (rd_en && cnt[0]) rd_rise <= rd_rise + 1;
            if (flag && !flag_q) cs_rise <= cs_rise + 1;
            if (flag && !flag_q && cs_rise > 0 && gap_run < min_gap) min_gap <= gap_run;
            gap_run <= flag ? 0 : gap_run + 1;
            if (bus.txn_done) dcnt <= dcnt + 1;
            if (bus.cmd_valid && bus.cmd_ready) acc <= acc + 1;
        end
        flag_q <= flag;
        if ((wr_en && rd_en) || flag != (wr_en | rd_en)) inv <= inv + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        clr_mon = 1'b1;
        @(posedge div_clk);
        #1 clr_mon = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic [7:0] a, input logic [23:0] d);
        int n = 0;
        @(negedge div_clk);
        bus.cmd_rw = rw; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 200) begin @(negedge div_clk); n++; end
        @(negedge div_clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge div_clk);
        while (!bus.txn_done && n < 2000) begin @(negedge div_clk); n++; end
        check(tag, 64'(bus.txn_done), 64'd1);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = 8'h0; bus.cmd_wdata = 24'h0;
        repeat (3) @(negedge div_clk);
        check("rst_outs", {wr_en, rd_en, flag, stage_rst, tx_data, bus.busy, bus.cmd_ready, bus.txn_done, bus.rsp_rdata},
              {4'b0, 8'h0, 1'b0, 1'b1, 1'b0, 24'h0});
        rst = 1'b0;
        repeat (2) @(negedge div_clk);

        // Register write
        clear();
        issue(1'b0, 8'h01, 24'hABCDEF);
        wait_done("wr_done");
        check("wr_gap", 64'(gap_run), 64'(CS_GAP));
        check("wr_mosi", mosi_sh[31:0], 64'h01ABCDEF);
        check("wr_cyc", 64'(wr_cyc), 64'd64);
        check("wr_rise", 64'(wr_rise), 64'd32);
        check("wr_rdcyc", 64'(rd_cyc), 64'd0);
        check("wr_cs", 64'(cs_rise), 64'd1);
        repeat (3) @(negedge div_clk);
        check("wr_dcnt", 64'(dcnt), 64'd1);
        check("wr_idle", {bus.busy, bus.cmd_ready}, 64'b01);

        // Register read
        clear();
        slave_val = 24'h123456;
        issue(1'b1, 8'h2A, 24'hFFFFFF);
        wait_done("rd_done");
        check("rd_data", bus.rsp_rdata, 64'h123456);
        check("rd_gap", 64'(gap_run), 64'(CS_GAP));
        check("rd_rise", 64'(rd_rise), 64'd24);
        check("rd_cyc", 64'(rd_cyc), 64'd49);
`ifdef AFE_SPI_RDEN_SEQ_EN
        check("rd_wrrise", 64'(wr_rise), 64'd72);
        check("rd_wrcyc", 64'(wr_cyc), 64'd144);
        check("rd_cs", 64'(cs_rise), 64'd3);
        check("rd_mosi", mosi_sh, 64'h0000012A00000000);
`else
        check("rd_wrrise", 64'(wr_rise), 64'd8);
        check("rd_wrcyc", 64'(wr_cyc), 64'd16);
        check("rd_cs", 64'(cs_rise), 64'd1);
        check("rd_mosi", mosi_sh[7:0], 64'h2A);
`endif
        repeat (3) @(negedge div_clk);
        check("rd_dcnt", 64'(dcnt), 64'd1);

        // Back-to-back with cmd_valid held
        clear();
        @(negedge div_clk);
        bus.cmd_rw = 1'b0; bus.cmd_addr = 8'h10; bus.cmd_wdata = 24'h111111; bus.cmd_valid = 1'b1;
        @(negedge div_clk);
        bus.cmd_addr = 8'h44; bus.cmd_wdata = 24'h5A5A5A;
        wait_done("b2b_done1");
        check("b2b_hold", 64'(acc), 64'd1);
        n = 0;
        while (!bus.cmd_ready && n < 10) begin @(negedge div_clk); n++; end
        @(negedge div_clk);
        bus.cmd_valid = 1'b0;
        wait_done("b2b_done2");
        check("b2b_acc", 64'(acc), 64'd2);
        check("b2b_mosi", mosi_sh, 64'h10111111445A5A5A);
        check("b2b_cs", 64'(cs_rise), 64'd2);
        check("b2b_mingap", 64'(min_gap), 64'd5);
        check("b2b_wrcyc", 64'(wr_cyc), 64'd128);

        // Reset in the middle of byte 2 of a write
        clear();
        issue(1'b0, 8'h05, 24'hDEAD01);
        n = 0;
        while (wr_cyc < 40 && n < 500) begin @(negedge div_clk); n++; end
        rst = 1'b1;
        #1;
        check("rst_mid", {wr_en, rd_en, flag, stage_rst, tx_data, bus.busy, bus.cmd_ready, bus.txn_done, bus.rsp_rdata},
              {4'b0, 8'h0, 1'b0, 1'b1, 1'b0, 24'h0});
        check("rst_spiste", 64'(spiste), 64'd1);
        @(negedge div_clk);
        rst = 1'b0;
        clear();
        issue(1'b0, 8'h06, 24'h0F0F0F);
        wait_done("post_rst_done");
        check("post_rst_mosi", mosi_sh[31:0], 64'h060F0F0F);
        check("post_rst_cyc", 64'(wr_cyc), 64'd64);

        // Spurious spi_done while idle
        repeat (2) @(negedge div_clk);
        clear();
        @(negedge div_clk);
        inj = 1'b1;
        @(negedge div_clk);
        inj = 1'b0;
        repeat (3) @(negedge div_clk);
        check("spur_state", {bus.busy, bus.cmd_ready, bus.txn_done}, 64'b010);
        check("spur_dcnt", 64'(dcnt), 64'd0);
        check("spur_bus", 64'(wr_cyc + rd_cyc), 64'd0);

        check("invariants", 64'(inv), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
